// File: rtl/vga_pkg.sv
// VGA 640x480@60 timing constants and shared types.
// Coordinates are 10-bit for both axes.
package vga_pkg;

  localparam int CW = 10;

  localparam int H_VISIBLE = 640;
  localparam int H_FP      = 16;
  localparam int H_SYNC    = 96;
  localparam int H_BP      = 48;
  localparam int H_TOTAL   = H_VISIBLE + H_FP + H_SYNC + H_BP;

  localparam int V_VISIBLE = 480;
  localparam int V_FP      = 10;
  localparam int V_SYNC    = 2;
  localparam int V_BP      = 33;
  localparam int V_TOTAL   = V_VISIBLE + V_FP + V_SYNC + V_BP;

  typedef logic [CW-1:0] coord_t;

  function automatic logic in_span(
    input coord_t v,
    input int     lo,
    input int     hi
  );
    return (int'(v) >= lo) && (int'(v) <= hi);
  endfunction

endpackage

// File: rtl/wrap_counter.sv
// Modulo counter with enable; resets to its last value so the
// first enabled step lands on zero and raises wrap.
module wrap_counter
  import vga_pkg::*;
#(
  parameter int MOD = 800
) (
  input  logic   clk_i,
  input  logic   rst_ni,
  input  logic   en_i,
  output coord_t cnt_o,
  output coord_t next_o,
  output logic   wrap_o
);

  localparam coord_t LAST = coord_t'(MOD - 1);

  coord_t cnt_q;

  // next value and wrap strobe, visible before the edge
  always_comb begin
    wrap_o = en_i && (cnt_q == LAST);
    next_o = cnt_q;
    if (en_i) begin
      next_o = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
    end
  end

  // count register
  always_ff @(posedge clk_i) begin
    if (!rst_ni) cnt_q <= LAST;
    else         cnt_q <= next_o;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/vga_sync_gen.sv
// VGA raster generator: pixel strobe, position counters and
// registered sync/blank decoded from the upcoming position.
module vga_sync_gen #(
  parameter int H_VISIBLE = vga_pkg::H_VISIBLE,
  parameter int H_FP      = vga_pkg::H_FP,
  parameter int H_SYNC    = vga_pkg::H_SYNC,
  parameter int H_BP      = vga_pkg::H_BP,
  parameter int V_VISIBLE = vga_pkg::V_VISIBLE,
  parameter int V_FP      = vga_pkg::V_FP,
  parameter int V_SYNC    = vga_pkg::V_SYNC,
  parameter int V_BP      = vga_pkg::V_BP
) (
  input  logic            Clk,
  input  logic            Reset_n,
  output logic            VGA_CLK,
  output logic            pix_en,
  output logic            VGA_HS,
  output logic            VGA_VS,
  output logic            VGA_BLANK_N,
  output logic            VGA_SYNC_N,
  output vga_pkg::coord_t DrawX,
  output vga_pkg::coord_t DrawY,
  output logic            frame_start,
  output logic            line_start
);

  import vga_pkg::*;

  localparam int HT    = H_VISIBLE + H_FP + H_SYNC + H_BP;
  localparam int VT    = V_VISIBLE + V_FP + V_SYNC + V_BP;
  localparam int HS_LO = H_VISIBLE + H_FP;
  localparam int HS_HI = HS_LO + H_SYNC - 1;
  localparam int VS_LO = V_VISIBLE + V_FP;
  localparam int VS_HI = VS_LO + V_SYNC - 1;

  logic   phase_q, phase_d;
  logic   pix_en_q;
  logic   hs_q, vs_q, blank_n_q;
  logic   fs_q, ls_q;
  logic   hs_d, vs_d, blank_n_d;
  coord_t x_q, x_nxt, y_q, y_nxt;
  logic   h_wrap, v_wrap;

  wrap_counter #(.MOD(HT)) u_hcnt (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .en_i   (pix_en_q),
    .cnt_o  (x_q),
    .next_o (x_nxt),
    .wrap_o (h_wrap)
  );

  wrap_counter #(.MOD(VT)) u_vcnt (
    .clk_i  (Clk),
    .rst_ni (Reset_n),
    .en_i   (h_wrap),
    .cnt_o  (y_q),
    .next_o (y_nxt),
    .wrap_o (v_wrap)
  );

  // decode from the position the counters are about to hold
  always_comb begin
    phase_d   = ~phase_q;
    hs_d      = ~in_span(x_nxt, HS_LO, HS_HI);
    vs_d      = ~in_span(y_nxt, VS_LO, VS_HI);
    blank_n_d = (int'(x_nxt) < H_VISIBLE) &&
                (int'(y_nxt) < V_VISIBLE);
  end

  // phase, strobe and decoded outputs share the counter edge
  always_ff @(posedge Clk) begin
    if (!Reset_n) begin
      phase_q   <= 1'b0;
      pix_en_q  <= 1'b0;
      hs_q      <= 1'b1;
      vs_q      <= 1'b1;
      blank_n_q <= 1'b0;
      fs_q      <= 1'b0;
      ls_q      <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      pix_en_q  <= phase_d;
      hs_q      <= hs_d;
      vs_q      <= vs_d;
      blank_n_q <= blank_n_d;
      fs_q      <= v_wrap;
      ls_q      <= h_wrap;
    end
  end

  assign VGA_CLK     = phase_q;
  assign pix_en      = pix_en_q;
  assign VGA_HS      = hs_q;
  assign VGA_VS      = vs_q;
  assign VGA_BLANK_N = blank_n_q;
  assign VGA_SYNC_N  = 1'b0;
  assign DrawX       = x_q;
  assign DrawY       = y_q;
  assign frame_start = fs_q;
  assign line_start  = ls_q;

endmodule
